// File: rtl/dmem_mmio_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_mmio_responder_if
//   Bundle of the core's data-port signals plus the TX drain port and the
//   simulation status outputs of dmem_mmio_responder.
//
//   master : the core / testbench side (drives address, store data, strobe,
//            and the TX sink ready).
//   slave  : the responder (drives load data, TX head byte/valid, done,
//            done_code and bad_access).
// ----------------------------------------------------------------------------
interface dmem_mmio_responder_if;
    logic [31:0] DataAddr;
    logic [31:0] write_data;
    logic        write_ena;
    logic [31:0] read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;
    logic [31:0] done_code;
    logic        bad_access;

    modport master (
        output DataAddr, write_data, write_ena, tx_ready,
        input  read_data, tx_data, tx_valid, done, done_code, bad_access
    );

    modport slave (
        input  DataAddr, write_data, write_ena, tx_ready,
        output read_data, tx_data, tx_valid, done, done_code, bad_access
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// ----------------------------------------------------------------------------
// dmem_mmio_responder
//   Data-side memory responder for the pipelined RISC-V core. Word RAM plus a
//   small MMIO block: byte TX FIFO with valid/ready drain, free-running cycle
//   counter and a DONE/exit register. Loads are combinational (same cycle),
//   stores commit on the rising edge of clk.
//
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     reset  : synchronous active-high reset (MMIO state only; RAM keeps data)
//     bus    : slave modport of dmem_mmio_responder_if
//              DataAddr/write_data/write_ena -> read_data  (core data port)
//              tx_data/tx_valid/tx_ready                     (TX drain port)
//              done/done_code/bad_access                     (status)
//
//   Address map (word accesses only):
//     0x0000_0000 .. RAM_WORDS*4-1 : RAM
//     0x8000_0000 TXDATA  W: push byte     R: 0
//     0x8000_0004 STATUS  R: {overflow, count[5:0], empty, full}, W ignored
//     0x8000_0008 CYCLE   R: counter       W: load counter
//     0x8000_000C DONE    R: done_code     W: done=1, done_code=data
// ----------------------------------------------------------------------------
module dmem_mmio_responder #(
    parameter int    RAM_WORDS  = 64,
    parameter int    FIFO_DEPTH = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_mmio_responder_if.slave  bus
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;
    localparam logic [1:0] REG_DONE   = 2'd3;

    // ------------------------------------------------------------------
    // Storage and registers
    // ------------------------------------------------------------------
    logic [31:0]   r_mem [RAM_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [31:0]   r_cycle;
    logic          r_done;
    logic [31:0]   r_done_code;
    logic          r_bad_access;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic              w_aligned;
    logic              w_in_ram;
    logic              w_in_mmio;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [1:0]        w_reg_sel;
    logic              w_wr_ok;

    assign w_aligned = (bus.DataAddr[1:0] == 2'b00);
    assign w_in_ram  = (bus.DataAddr[31:RAM_AW+2] == '0);
    assign w_in_mmio = (bus.DataAddr[31:4] == 28'h8000_000);
    assign w_ram_idx = bus.DataAddr[RAM_AW+1:2];
    assign w_reg_sel = bus.DataAddr[3:2];
    assign w_wr_ok   = bus.write_ena & w_aligned;

    logic w_wr_ram;
    logic w_wr_tx;
    logic w_wr_cycle;
    logic w_wr_done;
    logic w_wr_bad;

    assign w_wr_ram   = w_wr_ok & w_in_ram;
    assign w_wr_tx    = w_wr_ok & w_in_mmio & (w_reg_sel == REG_TXDATA);
    assign w_wr_cycle = w_wr_ok & w_in_mmio & (w_reg_sel == REG_CYCLE);
    assign w_wr_done  = w_wr_ok & w_in_mmio & (w_reg_sel == REG_DONE);
    // Misaligned stores and stores outside both regions are errors; a STATUS
    // store is a legal (ignored) access and does not count.
    assign w_wr_bad   = bus.write_ena & (~w_aligned | (~w_in_ram & ~w_in_mmio));

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic w_valid;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_accept;
    logic w_overflow_evt;

    assign w_valid        = (r_count != '0);
    assign w_empty        = ~w_valid;
    assign w_full         = (r_count == CW'(FIFO_DEPTH));
    assign w_pop          = w_valid & bus.tx_ready;
    // A pop on the same edge frees a slot, so a push into a full FIFO is
    // still accepted when the head is being drained.
    assign w_push_accept  = w_wr_tx & (~w_full | w_pop);
    assign w_overflow_evt = w_wr_tx & w_full & ~w_pop;

    // RAM commits regardless of reset: reset only clears MMIO state.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_mem[w_ram_idx] <= bus.write_data;
        end
    end

    // FIFO payload needs no reset; tx_data is gated by tx_valid.
    always_ff @(posedge clk) begin
        if (!reset && w_push_accept) begin
            r_fifo[r_wr_ptr] <= bus.write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push_accept && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_accept && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_overflow_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter, DONE register, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle      <= '0;
            r_done       <= 1'b0;
            r_done_code  <= '0;
            r_bad_access <= 1'b0;
        end else begin
            // A load replaces the increment for that cycle.
            if (w_wr_cycle) begin
                r_cycle <= bus.write_data;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_wr_done) begin
                r_done      <= 1'b1;
                r_done_code <= bus.write_data;
            end
            if (w_wr_bad) begin
                r_bad_access <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational load path
    // ------------------------------------------------------------------
    logic [5:0]  w_count6;
    logic [31:0] w_status;

    assign w_count6 = 6'(r_count);
    assign w_status = {23'd0, r_overflow, w_count6, w_empty, w_full};

    always_comb begin
        bus.read_data = 32'd0;
        if (w_aligned) begin
            if (w_in_ram) begin
                bus.read_data = r_mem[w_ram_idx];
            end else if (w_in_mmio) begin
                case (w_reg_sel)
                    REG_STATUS: bus.read_data = w_status;
                    REG_CYCLE:  bus.read_data = r_cycle;
                    REG_DONE:   bus.read_data = r_done_code;
                    default:    bus.read_data = 32'd0;
                endcase
            end
        end
    end

    assign bus.tx_valid   = w_valid;
    assign bus.tx_data    = w_valid ? r_fifo[r_rd_ptr] : 8'h00;
    assign bus.done       = r_done;
    assign bus.done_code  = r_done_code;
    assign bus.bad_access = r_bad_access;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    dmem_mmio_responder_if bus();

    dmem_mmio_responder #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(4),
        .INIT_FILE ("")
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] A_TX     = 32'h8000_0000;
    localparam logic [31:0] A_STATUS = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
    localparam logic [31:0] A_DONE   = 32'h8000_000C;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_bad;
    } vec_t;

    vec_t vecs [15];

    // Advance one clock; inputs are changed and outputs sampled on negedge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.DataAddr   = addr;
        bus.write_data = data;
        bus.write_ena  = 1'b1;
        cyc();
        bus.write_ena  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bus.DataAddr  = addr;
        bus.write_ena = 1'b0;
        #1;
        chk(name, bus.read_data, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bus.DataAddr   = 32'd0;
        bus.write_data = 32'd0;
        bus.write_ena  = 1'b0;
        bus.tx_ready   = 1'b0;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_done_code", bus.done_code, 32'd0);
        chk("rst_bad", {31'd0, bus.bad_access}, 32'd0);
        rd("rst_status", A_STATUS, 32'h0000_0002);
        rd("rst_cycle", A_CYCLE, 32'd0);

        // ---------------- counter ----------------
        reset = 1'b0;
        repeat (10) cyc();
        rd("cycle_after_10", A_CYCLE, 32'd10);
        wr(A_CYCLE, 32'hFFFF_FFFE);
        rd("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
        cyc();
        rd("cycle_load_p1", A_CYCLE, 32'hFFFF_FFFF);
        cyc();
        rd("cycle_wrap", A_CYCLE, 32'd0);

        // ---------------- table: RAM round trip and error handling ----------------
        vecs[0]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0,           1'b0};
        vecs[1]  = '{32'h0000_0014, 32'h1234_5678, 1'b1, 1'b0, 32'd0,           1'b0};
        vecs[2]  = '{32'h0000_0010, 32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF,   1'b0};
        vecs[3]  = '{32'h0000_0014, 32'd0,         1'b0, 1'b1, 32'h1234_5678,   1'b0};
        vecs[4]  = '{32'h0000_0012, 32'd0,         1'b0, 1'b1, 32'd0,           1'b0};
        vecs[5]  = '{32'h8000_0010, 32'd0,         1'b0, 1'b1, 32'd0,           1'b0};
        vecs[6]  = '{32'h0000_0100, 32'd0,         1'b0, 1'b1, 32'd0,           1'b0};
        vecs[7]  = '{A_STATUS,      32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0,           1'b0};
        vecs[8]  = '{A_STATUS,      32'd0,         1'b0, 1'b1, 32'h0000_0002,   1'b0};
        vecs[9]  = '{A_TX,          32'd0,         1'b0, 1'b1, 32'd0,           1'b0};
        vecs[10] = '{32'h4000_0000, 32'h0000_1234, 1'b1, 1'b0, 32'd0,           1'b1};
        vecs[11] = '{32'h4000_0000, 32'd0,         1'b0, 1'b1, 32'd0,           1'b1};
        vecs[12] = '{32'h0000_0012, 32'h1111_1111, 1'b1, 1'b0, 32'd0,           1'b1};
        vecs[13] = '{32'h0000_0010, 32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF,   1'b1};
        vecs[14] = '{32'h0000_0014, 32'd0,         1'b0, 1'b1, 32'h1234_5678,   1'b1};

        for (int i = 0; i < 15; i++) begin
            bus.DataAddr   = vecs[i].addr;
            bus.write_data = vecs[i].wdata;
            bus.write_ena  = vecs[i].we;
            #1;
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d_rd@%08h", i, vecs[i].addr), bus.read_data, vecs[i].exp_rd);
            end
            cyc();
            bus.write_ena = 1'b0;
            chk($sformatf("vec%0d_bad", i), {31'd0, bus.bad_access}, {31'd0, vecs[i].exp_bad});
        end

        // ---------------- misaligned write alone sets bad_access ----------------
        do_reset();
        chk("bad_cleared", {31'd0, bus.bad_access}, 32'd0);
        rd("ram_kept_after_reset", 32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0102, 32'h5555_5555);
        chk("misaligned_wr_bad", {31'd0, bus.bad_access}, 32'd1);
        rd("ram_unchanged", 32'h0000_0010, 32'hDEAD_BEEF);

        // ---------------- FIFO fill / overflow / drain ----------------
        do_reset();
        bus.tx_ready = 1'b0;
        wr(A_TX, 32'h0000_0041);
        chk("push_empty_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("push_empty_data", {24'd0, bus.tx_data}, 32'h41);
        wr(A_TX, 32'hFFFF_FF42);
        wr(A_TX, 32'h0000_0043);
        wr(A_TX, 32'h0000_0044);
        rd("status_full", A_STATUS, 32'h0000_0011);
        wr(A_TX, 32'h0000_0045);
        rd("status_overflow", A_STATUS, 32'h0000_0111);
        chk("hold_head", {24'd0, bus.tx_data}, 32'h41);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), {31'd0, bus.tx_valid}, 32'd1);
            chk($sformatf("drain%0d_data", i), {24'd0, bus.tx_data}, 32'h41 + i);
            cyc();
        end
        chk("drained_valid", {31'd0, bus.tx_valid}, 32'd0);
        bus.tx_ready = 1'b0;
        rd("status_drained", A_STATUS, 32'h0000_0102);

        // ---------------- simultaneous push/pop while full ----------------
        do_reset();
        rd("status_after_reset", A_STATUS, 32'h0000_0002);
        for (int i = 0; i < 4; i++) wr(A_TX, 32'h51 + i);
        rd("full_again", A_STATUS, 32'h0000_0011);
        bus.tx_ready = 1'b1;
        wr(A_TX, 32'h0000_0055);
        bus.tx_ready = 1'b0;
        rd("pushpop_status", A_STATUS, 32'h0000_0011);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain%0d", i), {24'd0, bus.tx_data}, 32'h52 + i);
            cyc();
        end
        bus.tx_ready = 1'b0;
        rd("pushpop_end_status", A_STATUS, 32'h0000_0002);

        // ---------------- DONE register and reset ----------------
        wr(A_DONE, 32'd7);
        chk("done_set", {31'd0, bus.done}, 32'd1);
        chk("done_code7", bus.done_code, 32'd7);
        rd("done_read", A_DONE, 32'd7);
        wr(A_DONE, 32'd9);
        chk("done_sticky", {31'd0, bus.done}, 32'd1);
        chk("done_code9", bus.done_code, 32'd9);
        wr(A_TX, 32'h0000_0077);
        chk("pending_byte", {31'd0, bus.tx_valid}, 32'd1);
        // Reset edge with a DONE write: MMIO write must be ignored.
        bus.DataAddr   = A_DONE;
        bus.write_data = 32'h0000_0099;
        bus.write_ena  = 1'b1;
        reset          = 1'b1;
        cyc();
        reset          = 1'b0;
        bus.write_ena  = 1'b0;
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_done_code", bus.done_code, 32'd0);
        chk("reset_fifo_empty", {31'd0, bus.tx_valid}, 32'd0);
        rd("reset_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
        // Reset edge with a RAM write: RAM commit still happens.
        bus.DataAddr   = 32'h0000_0020;
        bus.write_data = 32'h0000_ABCD;
        bus.write_ena  = 1'b1;
        reset          = 1'b1;
        cyc();
        reset          = 1'b0;
        bus.write_ena  = 1'b0;
        rd("reset_ram_write", 32'h0000_0020, 32'h0000_ABCD);
        chk("reset_bad", {31'd0, bus.bad_access}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
